// File: rtl/filter_cpipe_param_if.sv
// Sensor-filter bus: per-channel arm/sensor inputs and actuator/settled outputs.
// Glitch-counter signals exist only when FILTER_GLITCH_CNT_EN is defined.
interface filter_cpipe_param_if #(
    parameter int CHANNELS = 1,
    parameter int GLITCH_W = 8
);
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] sensor;
    logic [CHANNELS-1:0] actuator;
    logic [CHANNELS-1:0] settled;
`ifdef FILTER_GLITCH_CNT_EN
    logic                               glitch_clr;
    logic [CHANNELS-1:0][GLITCH_W-1:0]  glitch_cnt;

    modport master (output start, sensor, glitch_clr, input actuator, settled, glitch_cnt);
    modport slave  (input start, sensor, glitch_clr, output actuator, settled, glitch_cnt);
`else
    modport master (output start, sensor, input actuator, settled);
    modport slave  (input start, sensor, output actuator, settled);
`endif
endinterface

// File: rtl/filter_cpipe_param.sv
// Clocked multi-stage C-element sensor filter with per-stage hold counters.
// Optional per-channel glitch (abort) counters under FILTER_GLITCH_CNT_EN.
module filter_cpipe_chan #(
    parameter int STAGES = 3,
    parameter int HOLD   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sensor,
    output logic actuator,
`ifdef FILTER_GLITCH_CNT_EN
    output logic abort,
`endif
    output logic settled
);
    localparam int CW = $clog2(HOLD + 1);

    logic [STAGES:1]         q;
    logic [STAGES-1:0]       q_in;
    logic [STAGES:1]         cond;
    logic [STAGES:1]         abrt;
    logic [STAGES:1][CW-1:0] cnt;

    always_comb begin
        q_in    = '0;
        q_in[0] = start;
        for (int i = 1; i < STAGES; i++) q_in[i] = q[i];
    end

    // Set needs both inputs high, clear needs both low; disagreement holds.
    always_comb begin
        cond = '0;
        abrt = '0;
        for (int i = 1; i <= STAGES; i++) begin
            cond[i] = (q_in[i-1] & sensor & ~q[i]) | (~q_in[i-1] & ~sensor & q[i]);
            abrt[i] = ~cond[i] & (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            for (int i = 1; i <= STAGES; i++) begin
                if (cond[i]) begin
                    if (cnt[i] == CW'(HOLD - 1)) begin
                        q[i]   <= ~q[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign actuator = q[STAGES];
    assign settled  = (q == {STAGES{q[STAGES]}}) && (cnt == '0);
`ifdef FILTER_GLITCH_CNT_EN
    assign abort    = |abrt;
`endif
endmodule

module filter_cpipe_param #(
    parameter int CHANNELS = 1,
    parameter int STAGES   = 3,
    parameter int HOLD     = 5,
    parameter int GLITCH_W = 8
) (
    input logic clk,
    input logic rst_n,
    filter_cpipe_param_if.slave bus
);
    logic [CHANNELS-1:0] act;
    logic [CHANNELS-1:0] stl;
`ifdef FILTER_GLITCH_CNT_EN
    logic [CHANNELS-1:0]               abort;
    logic [CHANNELS-1:0][GLITCH_W-1:0] gcnt;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        filter_cpipe_chan #(.STAGES(STAGES), .HOLD(HOLD)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (bus.start[c]),
            .sensor   (bus.sensor[c]),
            .actuator (act[c]),
`ifdef FILTER_GLITCH_CNT_EN
            .abort    (abort[c]),
`endif
            .settled  (stl[c])
        );

`ifdef FILTER_GLITCH_CNT_EN
        // Clear beats a same-edge abort; count saturates instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                gcnt[c] <= '0;
            else if (bus.glitch_clr)
                gcnt[c] <= '0;
            else if (abort[c] && (gcnt[c] != {GLITCH_W{1'b1}}))
                gcnt[c] <= gcnt[c] + GLITCH_W'(1);
        end
`endif
    end

    assign bus.actuator = act;
    assign bus.settled  = stl;
`ifdef FILTER_GLITCH_CNT_EN
    assign bus.glitch_cnt = gcnt;
`endif
endmodule

// File: tb/tb_filter_cpipe_param.sv
// Directed bench: 2-channel/3-stage/HOLD=5 filter plus a HOLD=1 single-stage instance.
module tb_filter_cpipe_param;
    localparam int CH = 2, ST = 3, HD = 5, GW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    filter_cpipe_param_if #(.CHANNELS(CH), .GLITCH_W(GW)) bus ();
    filter_cpipe_param #(.CHANNELS(CH), .STAGES(ST), .HOLD(HD), .GLITCH_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    filter_cpipe_param_if #(.CHANNELS(1), .GLITCH_W(GW)) bus1 ();
    filter_cpipe_param #(.CHANNELS(1), .STAGES(1), .HOLD(1), .GLITCH_W(GW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start  = '0;
        bus.sensor = '0;
        bus1.start  = '0;
        bus1.sensor = '0;
`ifdef FILTER_GLITCH_CNT_EN
        bus.glitch_clr  = 1'b0;
        bus1.glitch_clr = 1'b0;
`endif
        #2;
        chk("rst_actuator", bus.actuator, 2'b00);
        chk("rst_settled", bus.settled, 2'b11);
`ifdef FILTER_GLITCH_CNT_EN
        chk("rst_glitch", bus.glitch_cnt, 4'h0);
`endif
        step(2);
        rst_n = 1'b1;

        // Arm ch0: actuator rises exactly 15 edges later
        bus.start  = 2'b01;
        bus.sensor = 2'b01;
        #1;
        chk("rise_no_comb", bus.actuator, 2'b00);
        step(14);
        chk("rise_e14_act", bus.actuator, 2'b00);
        chk("rise_e14_settled", bus.settled, 2'b10);
        step(1);
        chk("rise_e15_act", bus.actuator, 2'b01);
        chk("rise_e15_settled", bus.settled, 2'b11);

        // start dropping with sensor high never clears
        bus.start = 2'b00;
        step(30);
        chk("hold_act", bus.actuator, 2'b01);
        chk("hold_settled", bus.settled, 2'b11);

        bus.sensor = 2'b00;
        step(14);
        chk("fall_e14_act", bus.actuator, 2'b01);
        step(1);
        chk("fall_e15_act", bus.actuator, 2'b00);
        chk("fall_settled", bus.settled, 2'b11);

        // HOLD=1, single stage: plain registered C-element
        bus1.start  = 1'b1;
        bus1.sensor = 1'b1;
        #1;
        chk("h1_no_comb", bus1.actuator, 1'b0);
        step(1);
        chk("h1_rise", bus1.actuator, 1'b1);
        bus1.start = 1'b0;
        step(3);
        chk("h1_hold", bus1.actuator, 1'b1);
        bus1.sensor = 1'b0;
        step(1);
        chk("h1_fall", bus1.actuator, 1'b0);

        // 4-cycle sensor pulse: aborts at the 5th edge, nothing toggles
        bus.start  = 2'b01;
        bus.sensor = 2'b01;
        step(4);
        chk("pulse_counting", bus.settled, 2'b10);
        bus.sensor = 2'b00;
        step(1);
        chk("pulse_abort_settled", bus.settled, 2'b11);
        step(20);
        chk("pulse_act", bus.actuator, 2'b00);
`ifdef FILTER_GLITCH_CNT_EN
        chk("pulse_glitch", bus.glitch_cnt, 4'h1);
`endif
        bus.start = 2'b00;

        // Reset mid-propagation: q1=1 and stage-2 count=3 after 8 edges
        bus.start  = 2'b01;
        bus.sensor = 2'b01;
        step(8);
        chk("mid_settled", bus.settled, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_act", bus.actuator, 2'b00);
        chk("mid_rst_settled", bus.settled, 2'b11);
`ifdef FILTER_GLITCH_CNT_EN
        chk("mid_rst_glitch", bus.glitch_cnt, 4'h0);
`endif
        step(1);
        rst_n = 1'b1;
        step(14);
        chk("relaunch_e14", bus.actuator, 2'b00);
        step(1);
        chk("relaunch_e15", bus.actuator, 2'b01);
        bus.start  = 2'b00;
        bus.sensor = 2'b00;
        step(15);
        chk("relaunch_clear", bus.actuator, 2'b00);

        // Two channels: ch0 armed, ch1 sees two 3-cycle glitches
        bus.start  = 2'b11;
        bus.sensor = 2'b11;
        step(3);
        bus.sensor = 2'b01;
        step(3);
        bus.sensor = 2'b11;
        step(3);
        bus.sensor = 2'b01;
        step(3);
        step(2);
        chk("ch2_e14", bus.actuator, 2'b00);
        step(1);
        chk("ch2_e15", bus.actuator, 2'b01);
        chk("ch2_settled", bus.settled, 2'b11);
`ifdef FILTER_GLITCH_CNT_EN
        chk("ch2_glitch", bus.glitch_cnt, 4'b1000);

        bus.glitch_clr = 1'b1;
        step(1);
        bus.glitch_clr = 1'b0;
        chk("gclr_alone", bus.glitch_cnt, 4'h0);

        // Five ch1 glitches saturate a 2-bit counter at 3
        for (int k = 0; k < 5; k++) begin
            bus.sensor = 2'b11;
            step(2);
            bus.sensor = 2'b01;
            step(1);
            if (k == 1) chk("gsat_two", bus.glitch_cnt, 4'b1000);
        end
        chk("gsat_five", bus.glitch_cnt, 4'b1100);

        // Clear coincident with an abort wins
        bus.sensor = 2'b11;
        step(2);
        bus.sensor = 2'b01;
        bus.glitch_clr = 1'b1;
        step(1);
        bus.glitch_clr = 1'b0;
        chk("gclr_vs_abort", bus.glitch_cnt, 4'h0);
`endif
        chk("final_act", bus.actuator, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
